// File: rtl/serpent_inv_sbox_seq.sv
// Multi-cycle inverse Serpent S-box engine.
// A bitsliced 128-bit block is taken over a valid/ready handshake.
// SLICES_PER_CYCLE nibble slices are substituted in place on each RUN edge.
// The result is held in DONE until the downstream stage accepts it.
module serpent_inv_sbox_seq #(
    parameter int SLICES_PER_CYCLE = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [31:0]  i_word0,
    input  logic [31:0]  i_word1,
    input  logic [31:0]  i_word2,
    input  logic [31:0]  i_word3,
    input  logic [2:0]   i_Sbox_index,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_data,
    output logic         o_busy
);

    localparam int NPASS = 32 / SLICES_PER_CYCLE;
    localparam int KW    = (NPASS > 1) ? $clog2(NPASS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NPASS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [KW-1:0]    k;
    logic [2:0]       sbox_sel;
    logic [3:0][31:0] work;      // work[j] holds bitsliced word j
    logic [4:0]       base;

    logic [SLICES_PER_CYCLE-1:0][4:0] sidx;
    logic [SLICES_PER_CYCLE-1:0][3:0] nib_out;

    // Each table row lists outputs for inputs 0..15, first entry in the top nibble.
    function automatic logic [3:0] inv_sbox(input logic [2:0] sel, input logic [3:0] x);
        logic [63:0] row;
        row = 64'h0;
        case (sel)
            3'd0: row = 64'hD3B0_A65C_1E47_F982;
            3'd1: row = 64'h582E_F6C3_B479_1DA0;
            3'd2: row = 64'hC9F4_BE12_036D_58A7;
            3'd3: row = 64'h09A7_BE6D_35C2_48F1;
            3'd4: row = 64'h5083_A97E_2CB6_4FD1;
            3'd5: row = 64'h8F29_41DE_B653_7CA0;
            3'd6: row = 64'hFA1D_5360_49E7_2C8B;
            3'd7: row = 64'h306D_9EF8_5CB7_A142;
        endcase
        return row[{~x, 2'b00} +: 4];
    endfunction

    assign base = 5'(32'(k) * SLICES_PER_CYCLE);

    // One substitution lane per slice handled in a pass.
    for (genvar l = 0; l < SLICES_PER_CYCLE; l++) begin : g_lane
        logic [3:0] nib_in;
        assign sidx[l]    = base + 5'(l);
        assign nib_in     = {work[3][sidx[l]], work[2][sidx[l]],
                             work[1][sidx[l]], work[0][sidx[l]]};
        assign nib_out[l] = inv_sbox(sbox_sel, nib_in);
    end

    // Control FSM and in-place working register update.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            k        <= '0;
            sbox_sel <= '0;
            work     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        work     <= {i_word3, i_word2, i_word1, i_word0};
                        sbox_sel <= i_Sbox_index;
                        k        <= '0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int l = 0; l < SLICES_PER_CYCLE; l++) begin
                        for (int j = 0; j < 4; j++) begin
                            work[j][sidx[l]] <= nib_out[l][j];
                        end
                    end
                    k <= k + 1'b1;
                    if (k == K_LAST) state <= ST_DONE;
                end
                ST_DONE: begin
                    if (i_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_ready = (state == ST_IDLE);
    assign o_valid = (state == ST_DONE);
    assign o_busy  = (state != ST_IDLE);
    assign o_data  = work;

endmodule

// File: tb/tb_serpent_inv_sbox_seq.sv
// Bench for serpent_inv_sbox_seq: two instances (8 and 1 slices per cycle)
// share the input side; results are compared with a table-based slice model.
module tb_serpent_inv_sbox_seq;

    localparam int LAT8 = 4;
    localparam int LAT1 = 32;

    logic         clk = 1'b0;
    logic         rst_n, valid, ready;
    logic [31:0]  w0, w1, w2, w3;
    logic [2:0]   idx;
    logic         rdy8, vld8, busy8, rdy1, vld1, busy1;
    logic [127:0] data8, data1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serpent_inv_sbox_seq #(.SLICES_PER_CYCLE(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(rdy8),
        .i_word0(w0), .i_word1(w1), .i_word2(w2), .i_word3(w3),
        .i_Sbox_index(idx), .o_valid(vld8), .i_ready(ready),
        .o_data(data8), .o_busy(busy8)
    );

    serpent_inv_sbox_seq #(.SLICES_PER_CYCLE(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(rdy1),
        .i_word0(w0), .i_word1(w1), .i_word2(w2), .i_word3(w3),
        .i_Sbox_index(idx), .o_valid(vld1), .i_ready(ready),
        .o_data(data1), .o_busy(busy1)
    );

    int inv_t [8][16] = '{
        '{13, 3, 11, 0, 10, 6, 5, 12, 1, 14, 4, 7, 15, 9, 8, 2},
        '{5, 8, 2, 14, 15, 6, 12, 3, 11, 4, 7, 9, 1, 13, 10, 0},
        '{12, 9, 15, 4, 11, 14, 1, 2, 0, 3, 6, 13, 5, 8, 10, 7},
        '{0, 9, 10, 7, 11, 14, 6, 13, 3, 5, 12, 2, 4, 8, 15, 1},
        '{5, 0, 8, 3, 10, 9, 7, 14, 2, 12, 11, 6, 4, 15, 13, 1},
        '{8, 15, 2, 9, 4, 1, 13, 14, 11, 6, 5, 3, 7, 12, 10, 0},
        '{15, 10, 1, 13, 5, 3, 6, 0, 4, 9, 14, 7, 2, 12, 8, 11},
        '{3, 0, 6, 13, 9, 14, 15, 8, 5, 12, 11, 7, 10, 1, 4, 2}
    };
    int fwd_t [8][16];

    typedef struct {
        logic [31:0]  w0, w1, w2, w3;
        logic [2:0]   idx;
        logic [127:0] exp;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Substitute every slice of a {w3,w2,w1,w0} block through one table.
    function automatic logic [127:0] sub_block(input logic [127:0] b, input int s, input bit fwd);
        logic [127:0] r;
        int n, m;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            n = int'(b[96+i]) * 8 + int'(b[64+i]) * 4 + int'(b[32+i]) * 2 + int'(b[i]);
            m = fwd ? fwd_t[s][n] : inv_t[s][n];
            for (int j = 0; j < 4; j++) r[32*j+i] = 1'((m >> j) & 1);
        end
        return r;
    endfunction

    task automatic pop(input logic [127:0] exp, input string tag);
        @(negedge clk);
        valid = 1'b0;
        ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        chk({tag, " pop rdy8"}, rdy8, 1);
        chk({tag, " pop vld8"}, vld8, 0);
        chk({tag, " pop rdy1"}, rdy1, 1);
        chk({tag, " pop vld1"}, vld1, 0);
        chk({tag, " pop data8 kept"}, data8, exp);
    endtask

    // Present one block, scramble inputs while busy, measure latency, check result.
    task automatic run_block(input logic [127:0] blk, input logic [2:0] s,
                             input logic [127:0] exp, input string tag, input bit hold);
        int lat8 = -1;
        int lat1 = -1;
        @(negedge clk);
        {w3, w2, w1, w0} = blk;
        idx   = s;
        valid = 1'b1;
        ready = 1'b0;
        chk({tag, " rdy8"}, rdy8, 1);
        chk({tag, " rdy1"}, rdy1, 1);
        @(posedge clk);
        for (int e = 1; e <= 40; e++) begin
            #1;
            valid = 1'($urandom_range(0, 1));
            {w3, w2, w1, w0} = {$urandom, $urandom, $urandom, $urandom};
            idx = 3'($urandom_range(0, 7));
            @(posedge clk);
            #1;
            if (vld8 && lat8 < 0) lat8 = e;
            if (vld1 && lat1 < 0) lat1 = e;
            if (lat8 >= 0 && lat1 >= 0) break;
        end
        chk({tag, " lat8"}, 128'(lat8), LAT8);
        chk({tag, " lat1"}, 128'(lat1), LAT1);
        chk({tag, " data8"}, data8, exp);
        chk({tag, " data1"}, data1, exp);
        chk({tag, " busy8"}, busy8, 1);
        if (!hold) pop(exp, tag);
    endtask

    initial begin
        logic [127:0] p, c, e;
        logic [2:0]   s;

        for (int t = 0; t < 8; t++)
            for (int x = 0; x < 16; x++) fwd_t[t][inv_t[t][x]] = x;

        vecs[0] = '{32'h0, 32'h0, 32'h0, 32'h0, 3'd0,
                    128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd7,
                    128'h00000000_00000000_FFFFFFFF_00000000};
        vecs[2] = '{32'h1, 32'h0, 32'h0, 32'h0, 3'd3,
                    128'h00000001_00000000_00000000_00000001};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd0,
                    128'h00000000_00000000_FFFFFFFF_00000000};
        vecs[4] = '{32'h0, 32'h0, 32'h0, 32'h80000000, 3'd1,
                    128'h80000000_7FFFFFFF_80000000_FFFFFFFF};

        rst_n = 1'b1; valid = 1'b0; ready = 1'b0;
        w0 = '0; w1 = '0; w2 = '0; w3 = '0; idx = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset vld8", vld8, 0);
        chk("reset rdy8", rdy8, 1);
        chk("reset busy8", busy8, 0);
        chk("reset data8", data8, 0);
        chk("reset vld1", vld1, 0);
        chk("reset rdy1", rdy1, 1);
        chk("reset busy1", busy1, 0);
        chk("reset data1", data1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Known-answer vectors
        for (int i = 0; i < 5; i++)
            run_block({vecs[i].w3, vecs[i].w2, vecs[i].w1, vecs[i].w0},
                      vecs[i].idx, vecs[i].exp, $sformatf("vec%0d", i), 1'b0);

        // Forward S-box then engine must give back the original block
        for (int t = 0; t < 8; t++) begin
            for (int r = 0; r < 2; r++) begin
                p = {$urandom, $urandom, $urandom, $urandom};
                c = sub_block(p, t, 1'b1);
                run_block(c, 3'(t), p, $sformatf("rt s%0d", t), 1'b0);
            end
            c = {$urandom, $urandom, $urandom, $urandom};
            run_block(c, 3'(t), sub_block(c, t, 1'b0), $sformatf("inv s%0d", t), 1'b0);
        end

        // Stall in DONE while the input side is scrambled
        p = {$urandom, $urandom, $urandom, $urandom};
        s = 3'($urandom_range(0, 7));
        e = sub_block(p, int'(s), 1'b0);
        run_block(p, s, e, "stall", 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            valid = ~valid;
            {w3, w2, w1, w0} = {$urandom, $urandom, $urandom, $urandom};
            idx = 3'($urandom_range(0, 7));
            @(negedge clk);
            chk("stall data8", data8, e);
            chk("stall data1", data1, e);
            chk("stall rdy8", rdy8, 0);
            chk("stall rdy1", rdy1, 0);
        end
        pop(e, "stall");

        // Reset in the middle of RUN (k==2 for the 8-slice instance)
        @(negedge clk);
        {w3, w2, w1, w0} = {$urandom, $urandom, $urandom, $urandom};
        idx   = 3'd5;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst vld8", vld8, 0);
        chk("midrst rdy8", rdy8, 1);
        chk("midrst busy8", busy8, 0);
        chk("midrst data8", data8, 0);
        chk("midrst vld1", vld1, 0);
        chk("midrst rdy1", rdy1, 1);
        chk("midrst data1", data1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        p = {$urandom, $urandom, $urandom, $urandom};
        run_block(p, 3'd2, sub_block(p, 2, 1'b0), "postrst", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
